// File: rtl/instruction_fetch.sv
// Two-phase instruction fetch/issue unit. It fetches from a program memory with
// one cycle of read latency, then resolves HLT/JMP/BEQ/BNE or issues the instruction.
module instruction_fetch #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic [ADDR_W-1:0] pm_address,
    input  logic [DATA_W-1:0] pm_data,
    input  logic              zero_flag,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              halted
);

    localparam logic [4:0] OP_HLT = 5'b00000;
    localparam logic [4:0] OP_JMP = 5'b01000;
    localparam logic [4:0] OP_BEQ = 5'b01001;
    localparam logic [4:0] OP_BNE = 5'b01010;

    typedef enum logic [1:0] {
        S_FETCH,
        S_ISSUE,
        S_HALT
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              valid_q, valid_d;
    logic              halted_q, halted_d;

    logic [4:0]        opcode;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_plus_one;

    // Branch targets are zero-extended from the 11-bit operand, so they cannot reach above 2047.
    assign opcode      = pm_data[DATA_W-1 -: 5];
    assign target      = ADDR_W'(pm_data[10:0]);
    assign pc_plus_one = pc_q + ADDR_W'(1);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = 1'b0;
        halted_d   = halted_q;

        unique case (state_q)
            S_FETCH: begin
                if (enable) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (enable) begin
                    state_d = S_FETCH;
                    case (opcode)
                        OP_HLT: begin
                            state_d  = S_HALT;
                            halted_d = 1'b1;
                        end
                        OP_JMP: pc_d = target;
                        OP_BEQ: pc_d = zero_flag ? target : pc_plus_one;
                        OP_BNE: pc_d = zero_flag ? pc_plus_one : target;
                        default: begin
                            instr_d    = pm_data;
                            instr_pc_d = pc_q;
                            valid_d    = 1'b1;
                            pc_d       = pc_plus_one;
                        end
                    endcase
                end
            end
            S_HALT: begin
                // Only reset leaves HALT; enable is deliberately ignored here.
            end
            default: state_d = S_FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_FETCH;
            pc_q       <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            halted_q   <= halted_d;
        end
    end

    assign pm_address  = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed decode vectors, multi-cycle sequences, and a
// randomized run compared against an architectural-level reference model.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        zero_flag;
    logic [11:0] pm_address;
    logic [15:0] pm_data;
    logic [15:0] instr;
    logic        instr_valid;
    logic [11:0] instr_pc;
    logic        halted;

    logic [15:0] mem [4096];

    int n_vec = 0;
    int n_err = 0;

    instruction_fetch #(.ADDR_W(12), .DATA_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .pm_address (pm_address),
        .pm_data    (pm_data),
        .zero_flag  (zero_flag),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_pc   (instr_pc),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    // Synchronous program memory: data for an address appears one cycle later.
    always @(posedge clk) pm_data <= mem[pm_address];

    typedef struct {
        logic [11:0] start;
        logic [15:0] word;
        logic        zf;
        logic [11:0] exp_pc;
        logic        exp_valid;
        logic        exp_halted;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_mem(input logic [15:0] w);
        for (int i = 0; i < 4096; i++) mem[i] = w;
    endtask

    task automatic do_reset();
        rst    = 1'b0;
        enable = 1'b1;
        step();
        step();
        rst = 1'b1;
    endtask

    // Reference model: architectural state plus whether a fetched word is in flight.
    logic [11:0] m_pc;
    logic        m_halted;
    logic        m_inflight;
    logic [15:0] m_instr;
    logic [11:0] m_ipc;
    logic        m_valid;

    task automatic model_edge(input logic r, input logic en, input logic zf);
        logic [15:0] w;
        logic [11:0] tgt;
        m_valid = 1'b0;
        if (!r) begin
            m_pc = 0; m_halted = 0; m_inflight = 0; m_instr = 0; m_ipc = 0;
        end else if (!m_halted && en) begin
            if (!m_inflight) begin
                m_inflight = 1'b1;
            end else begin
                m_inflight = 1'b0;
                w   = mem[m_pc];
                tgt = {1'b0, w[10:0]};
                case (w[15:11])
                    5'd0:  m_halted = 1'b1;
                    5'd8:  m_pc = tgt;
                    5'd9:  m_pc = zf ? tgt : m_pc + 12'd1;
                    5'd10: m_pc = zf ? m_pc + 12'd1 : tgt;
                    default: begin
                        m_instr = w;
                        m_ipc   = m_pc;
                        m_valid = 1'b1;
                        m_pc    = m_pc + 12'd1;
                    end
                endcase
            end
        end
    endtask

    function automatic logic [15:0] rand_word();
        logic [10:0] opnd;
        opnd = 11'($urandom);
        case ($urandom_range(0, 15))
            0:       return {5'd0, opnd};
            1, 2:    return {5'd8, opnd};
            3:       return {5'd9, opnd};
            4:       return {5'd10, opnd};
            default: return {5'($urandom_range(11, 31)), opnd};
        endcase
    endfunction

    initial begin
        bit found;
        rst = 1'b0; enable = 1'b0; zero_flag = 1'b0;
        fill_mem(16'h1000);

        vecs[0]  = '{12'd0,    16'h480A, 1'b0, 12'd1,    1'b0, 1'b0};
        vecs[1]  = '{12'd0,    16'h480A, 1'b1, 12'd10,   1'b0, 1'b0};
        vecs[2]  = '{12'd0,    16'h500A, 1'b0, 12'd10,   1'b0, 1'b0};
        vecs[3]  = '{12'd0,    16'h500A, 1'b1, 12'd1,    1'b0, 1'b0};
        vecs[4]  = '{12'd0,    16'h4064, 1'b0, 12'd100,  1'b0, 1'b0};
        vecs[5]  = '{12'd5,    16'h0000, 1'b0, 12'd5,    1'b0, 1'b1};
        vecs[6]  = '{12'd7,    16'h1005, 1'b0, 12'd8,    1'b1, 1'b0};
        vecs[7]  = '{12'd0,    16'h47FF, 1'b0, 12'd2047, 1'b0, 1'b0};
        vecs[8]  = '{12'd2047, 16'h4FFF, 1'b1, 12'd2047, 1'b0, 1'b0};
        vecs[9]  = '{12'd300,  16'h57FF, 1'b1, 12'd301,  1'b0, 1'b0};
        vecs[10] = '{12'd9,    16'h5801, 1'b0, 12'd10,   1'b1, 1'b0};
        vecs[11] = '{12'd2046, 16'hF8AA, 1'b0, 12'd2047, 1'b1, 1'b0};
        vecs[12] = '{12'd3,    16'h0123, 1'b0, 12'd3,    1'b0, 1'b1};

        // Reset state.
        do_reset();
        check("reset pm_address", 32'(pm_address), 0);
        check("reset instr_valid", 32'(instr_valid), 0);
        check("reset halted", 32'(halted), 0);
        check("reset instr", 32'(instr), 0);
        check("reset instr_pc", 32'(instr_pc), 0);

        // Single-instruction decode vectors; nonzero starts are reached via JMP from 0.
        for (int i = 0; i < 13; i++) begin
            fill_mem(16'h1000);
            if (vecs[i].start != 0) mem[0] = {5'd8, vecs[i].start[10:0]};
            mem[vecs[i].start] = vecs[i].word;
            zero_flag = vecs[i].zf;
            do_reset();
            if (vecs[i].start != 0) begin
                step(); step();
                check($sformatf("vec%0d reach start", i), 32'(pm_address), 32'(vecs[i].start));
            end
            step(); step();
            check($sformatf("vec%0d next pc", i), 32'(pm_address), 32'(vecs[i].exp_pc));
            check($sformatf("vec%0d valid", i), 32'(instr_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d halted", i), 32'(halted), 32'(vecs[i].exp_halted));
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d instr", i), 32'(instr), 32'(vecs[i].word));
                check($sformatf("vec%0d instr_pc", i), 32'(instr_pc), 32'(vecs[i].start));
            end
        end
        zero_flag = 1'b0;

        // Sequential run ending in HLT, then reset while halted.
        fill_mem(16'h1000);
        mem[0] = 16'h1005; mem[1] = 16'h2003; mem[2] = 16'h0000;
        do_reset();
        step();
        check("seq fetch no strobe", 32'(instr_valid), 0);
        step();
        check("seq s0 valid", 32'(instr_valid), 1);
        check("seq s0 pc", 32'(instr_pc), 0);
        check("seq s0 instr", 32'(instr), 32'h1005);
        step();
        check("seq strobe one cycle", 32'(instr_valid), 0);
        step();
        check("seq s1 valid", 32'(instr_valid), 1);
        check("seq s1 pc", 32'(instr_pc), 1);
        check("seq s1 instr", 32'(instr), 32'h2003);
        step(); step();
        check("seq halted", 32'(halted), 1);
        check("seq halt valid", 32'(instr_valid), 0);
        enable = 1'b0; step(); enable = 1'b1; step(); step(); step();
        check("seq halt held", 32'(halted), 1);
        check("seq halt pm held", 32'(pm_address), 2);
        check("seq instr held", 32'(instr), 32'h2003);
        rst = 1'b0; step(); rst = 1'b1;
        check("halt reset halted", 32'(halted), 0);
        check("halt reset pm", 32'(pm_address), 0);

        // Jump skips the strobe and the next issue comes from the target.
        fill_mem(16'h1000);
        mem[0] = 16'h4064; mem[100] = 16'h1001;
        do_reset();
        step(); step();
        check("jmp no strobe", 32'(instr_valid), 0);
        check("jmp pm", 32'(pm_address), 100);
        step(); step();
        check("jmp tgt valid", 32'(instr_valid), 1);
        check("jmp tgt pc", 32'(instr_pc), 100);
        check("jmp tgt instr", 32'(instr), 32'h1001);

        // Stall during ISSUE: no strobe, address frozen, then issue resumes.
        fill_mem(16'h1000);
        mem[0] = 16'h1005;
        do_reset();
        step();
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall valid", 32'(instr_valid), 0);
            check("stall pm", 32'(pm_address), 0);
        end
        enable = 1'b1;
        step();
        check("stall resume valid", 32'(instr_valid), 1);
        check("stall resume instr", 32'(instr), 32'h1005);
        check("stall resume pm", 32'(pm_address), 1);

        // Reset asserted mid-ISSUE; the following fetch is from address 0.
        do_reset();
        step();
        rst = 1'b0; step(); rst = 1'b1;
        check("midissue rst pm", 32'(pm_address), 0);
        check("midissue rst valid", 32'(instr_valid), 0);
        step(); step();
        check("midissue refetch pc", 32'(instr_pc), 0);
        check("midissue refetch valid", 32'(instr_valid), 1);

        // PC wrap: JMP 2047, then straight-line code up to 4095.
        fill_mem(16'h1000);
        mem[0] = 16'h47FF;
        do_reset();
        found = 1'b0;
        for (int c = 0; c < 6000 && !found; c++) begin
            step();
            if (instr_valid && instr_pc == 12'd4095) found = 1'b1;
        end
        check("wrap reached 4095", 32'(found), 1);
        check("wrap pm", 32'(pm_address), 0);

        // Randomized run against the reference model.
        for (int i = 0; i < 4096; i++) mem[i] = rand_word();
        rst = 1'b0; enable = 1'b1;
        model_edge(1'b0, 1'b1, 1'b0);
        step();
        for (int c = 0; c < 4000; c++) begin
            rst       = ($urandom_range(0, 59) != 0);
            enable    = ($urandom_range(0, 3) != 0);
            zero_flag = 1'($urandom);
            model_edge(rst, enable, zero_flag);
            step();
            if ({pm_address, instr_valid, halted, instr, instr_pc} !==
                {m_pc, m_valid, m_halted, m_instr, m_ipc}) begin
                $display("FAIL rand cyc%0d: got pc=%0d v=%0b h=%0b i=%h ipc=%0d expected pc=%0d v=%0b h=%0b i=%h ipc=%0d",
                         c, pm_address, instr_valid, halted, instr, instr_pc,
                         m_pc, m_valid, m_halted, m_instr, m_ipc);
                n_err++;
            end
            n_vec++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
